// File: rtl/dpsk_pkg.sv
`default_nettype none
// ============================================================================
// dpsk_pkg : shared types and defaults for the DPSK deframer
// Rev 1.0
// ============================================================================
package dpsk_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEN   = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h2DD4;
    localparam int          DEFAULT_MAX_LEN   = 32;

endpackage
`default_nettype wire

// File: rtl/dpsk_bit_decide.sv
`default_nettype none
// ============================================================================
// dpsk_bit_decide : differential dot-product bit decision with squelch
// Rev 1.0
// ============================================================================
module dpsk_bit_decide
    import dpsk_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SQUELCH    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce_i,
    input  logic                         strobe_i,
    input  logic                         sync_i,
    input  logic signed [DATA_WIDTH-1:0] di_i,
    input  logic signed [DATA_WIDTH-1:0] dq_i,
    output logic                         raw_bit_o,
    output logic                         raw_valid_o,
    output logic                         squelch_o
);

    localparam int              SW     = DATA_WIDTH + 1;
    localparam int              PW     = 2 * DATA_WIDTH + 1;
    localparam logic [SW-1:0]   SQ_THR = SW'(SQUELCH);

    logic signed [DATA_WIDTH-1:0] di_prev_q, dq_prev_q;
    logic                         prev_valid_q;
    logic                         raw_bit_q, raw_valid_q, squelch_q;

    logic                  sym;
    logic [DATA_WIDTH-1:0] mag_i, mag_q;
    logic [SW-1:0]         mag_sum;
    logic signed [PW-1:0]  di_x, dq_x, dip_x, dqp_x, dot;

    assign sym = ce_i & strobe_i & sync_i;

    // Magnitude of the most negative code is 2^(W-1), which still fits unsigned.
    assign mag_i   = di_i[DATA_WIDTH-1] ? $unsigned(-di_i) : $unsigned(di_i);
    assign mag_q   = dq_i[DATA_WIDTH-1] ? $unsigned(-dq_i) : $unsigned(dq_i);
    assign mag_sum = {1'b0, mag_i} + {1'b0, mag_q};

    assign di_x  = PW'(di_i);
    assign dq_x  = PW'(dq_i);
    assign dip_x = PW'(di_prev_q);
    assign dqp_x = PW'(dq_prev_q);
    assign dot   = di_x * dip_x + dq_x * dqp_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            di_prev_q    <= '0;
            dq_prev_q    <= '0;
            prev_valid_q <= 1'b0;
            raw_bit_q    <= 1'b0;
            raw_valid_q  <= 1'b0;
            squelch_q    <= 1'b0;
        end else begin
            raw_valid_q <= 1'b0;
            squelch_q   <= 1'b0;
            if (sym) begin
                if (mag_sum < SQ_THR) begin
                    prev_valid_q <= 1'b0;
                    squelch_q    <= 1'b1;
                end else begin
                    di_prev_q    <= di_i;
                    dq_prev_q    <= dq_i;
                    prev_valid_q <= 1'b1;
                    raw_valid_q  <= prev_valid_q;
                    raw_bit_q    <= dot[PW-1];
                end
            end
        end
    end

    assign raw_bit_o   = raw_bit_q;
    assign raw_valid_o = raw_valid_q;
    assign squelch_o   = squelch_q;

endmodule
`default_nettype wire

// File: rtl/dpsk_deframer.sv
`default_nettype none
// ============================================================================
// dpsk_deframer : sync hunt, length/payload/checksum deframing of DPSK bits
// Rev 1.0
// ============================================================================
module dpsk_deframer
    import dpsk_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter logic [15:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
    parameter int          MAX_LEN    = DEFAULT_MAX_LEN,
    parameter int          SQUELCH    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic                         strobe_in,
    input  logic                         sync_in,
    input  logic signed [DATA_WIDTH-1:0] DI_in,
    input  logic signed [DATA_WIDTH-1:0] DQ_in,
    output logic                         bit_out,
    output logic                         bit_valid,
    output logic [7:0]                   byte_out,
    output logic                         byte_valid,
    output logic                         frame_start,
    output logic                         frame_ok,
    output logic                         frame_err,
    output logic                         locked
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e      state_q, state_d;
    logic        pol_q, pol_d;
    logic [15:0] shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  bytecnt_q, bytecnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  byte_q, byte_d;
    logic        byte_valid_q, byte_valid_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;

    logic        raw_bit, raw_valid, squelch;
    logic        dec_bit, start;
    logic [15:0] shift_next;

    dpsk_bit_decide #(
        .DATA_WIDTH (DATA_WIDTH),
        .SQUELCH    (SQUELCH)
    ) u_bit_decide (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce),
        .strobe_i    (strobe_in),
        .sync_i      (sync_in),
        .di_i        (DI_in),
        .dq_i        (DQ_in),
        .raw_bit_o   (raw_bit),
        .raw_valid_o (raw_valid),
        .squelch_o   (squelch)
    );

    // pol is cleared whenever the FSM falls back to HUNT, so the hunt compares raw bits.
    assign dec_bit    = raw_bit ^ pol_q;
    assign shift_next = {shift_q[14:0], dec_bit};

    always_comb begin
        state_d      = state_q;
        pol_d        = pol_q;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        bytecnt_d    = bytecnt_q;
        csum_d       = csum_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        ok_d         = 1'b0;
        err_d        = 1'b0;
        start        = 1'b0;
        if (squelch && state_q != ST_HUNT) begin
            err_d    = 1'b1;
            state_d  = ST_HUNT;
            pol_d    = 1'b0;
            bitcnt_d = 3'd0;
        end else if (raw_valid) begin
            shift_d  = shift_next;
            bitcnt_d = bitcnt_q + 3'd1;
            case (state_q)
                ST_HUNT: begin
                    bitcnt_d = 3'd0;
                    if (shift_next == SYNC_WORD || shift_next == ~SYNC_WORD) begin
                        start   = 1'b1;
                        pol_d   = (shift_next != SYNC_WORD);
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (bitcnt_q == 3'd7) begin
                        if (shift_next[7:0] == 8'd0 || shift_next[7:0] > MAX_LEN_B) begin
                            err_d   = 1'b1;
                            state_d = ST_HUNT;
                            pol_d   = 1'b0;
                        end else begin
                            state_d   = ST_DATA;
                            csum_d    = 8'd0;
                            bytecnt_d = shift_next[7:0];
                        end
                    end
                end
                ST_DATA: begin
                    if (bitcnt_q == 3'd7) begin
                        byte_d       = shift_next[7:0];
                        byte_valid_d = 1'b1;
                        csum_d       = csum_q + shift_next[7:0];
                        bytecnt_d    = bytecnt_q - 8'd1;
                        if (bytecnt_q == 8'd1) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (bitcnt_q == 3'd7) begin
                        ok_d    = (shift_next[7:0] == csum_q);
                        err_d   = (shift_next[7:0] != csum_q);
                        state_d = ST_HUNT;
                        shift_d = 16'd0;
                        pol_d   = 1'b0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            pol_q        <= 1'b0;
            shift_q      <= 16'd0;
            bitcnt_q     <= 3'd0;
            bytecnt_q    <= 8'd0;
            csum_q       <= 8'd0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pol_q        <= pol_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            bytecnt_q    <= bytecnt_d;
            csum_q       <= csum_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
        end
    end

    // Outputs are forced low for the whole reset window, including the first cycle.
    assign bit_out     = dec_bit & ~rst;
    assign bit_valid   = raw_valid & ~rst;
    assign frame_start = start & ~rst;
    assign byte_out    = byte_q & {8{~rst}};
    assign byte_valid  = byte_valid_q & ~rst;
    assign frame_ok    = ok_q & ~rst;
    assign frame_err   = err_q & ~rst;
    assign locked      = (state_q != ST_HUNT) & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_dpsk_deframer.sv
`default_nettype none
// ============================================================================
// tb_dpsk_deframer : table vectors for bit decisions, scoreboarded frame tests
// Rev 1.0
// ============================================================================
module tb_dpsk_deframer;

    localparam int          W    = 16;
    localparam logic [15:0] SYNC = 16'h2DD4;
    localparam int EV_START = 32'h100;
    localparam int EV_BYTE  = 32'h200;
    localparam int EV_OK    = 32'h300;
    localparam int EV_ERR   = 32'h400;

    logic clk = 1'b0;
    logic rst = 1'b1, ce = 1'b0, strobe_in = 1'b0, sync_in = 1'b0;
    logic signed [W-1:0] DI_in = '0, DQ_in = '0;
    logic       bit_out, bit_valid, byte_valid, frame_start, frame_ok, frame_err, locked;
    logic [7:0] byte_out;

    always #5 clk = ~clk;

    dpsk_deframer #(.DATA_WIDTH(W), .SYNC_WORD(SYNC), .MAX_LEN(32), .SQUELCH(64)) dut (
        .clk(clk), .rst(rst), .ce(ce), .strobe_in(strobe_in), .sync_in(sync_in),
        .DI_in(DI_in), .DQ_in(DQ_in), .bit_out(bit_out), .bit_valid(bit_valid),
        .byte_out(byte_out), .byte_valid(byte_valid), .frame_start(frame_start),
        .frame_ok(frame_ok), .frame_err(frame_err), .locked(locked)
    );

    typedef struct { int di; int dq; int v; int b; } vec_t;
    vec_t tbl[12];

    int n_cmp = 0, n_bad = 0;
    int exp_bitq[$];
    int exp_evq[$];
    bit mon_en = 1'b0;
    bit prev_bv = 1'b0;
    int ph = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic ev(input int act);
        if (exp_evq.size() == 0) check("event_unexpected", act, 0);
        else check("event", act, exp_evq.pop_front());
    endtask

    task automatic monitor();
        if (bit_valid) begin
            if (exp_bitq.size() == 0) check("bit_unexpected", bit_valid, 0);
            else check("bit_value", bit_out, exp_bitq.pop_front());
        end
        if (frame_ok || frame_err) check("ok_err_exclusive", frame_ok & frame_err, 0);
        if (frame_start) ev(EV_START);
        if (byte_valid) begin
            check("byte_latency", prev_bv, 1);
            ev(EV_BYTE | int'(byte_out));
        end
        if (frame_ok)  ev(EV_OK);
        if (frame_err) ev(EV_ERR);
        prev_bv = bit_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_en) monitor();
    endtask

    function automatic logic [14:0] outvec();
        return {bit_out, bit_valid, byte_out, byte_valid, frame_start, frame_ok, frame_err, locked};
    endfunction

    // One symbol event, then a ce=0 cycle with strobe/sync high that must be ignored.
    task automatic send_sym(input int di, input int dq);
        DI_in = W'(di); DQ_in = W'(dq);
        ce = 1'b1; strobe_in = 1'b1; sync_in = 1'b1;
        tick();
        ce = 1'b0; DI_in = W'($urandom_range(0, 4000)); DQ_in = W'(-1000);
        tick();
        strobe_in = 1'b0; sync_in = 1'b0;
    endtask

    task automatic send_raw(input bit r);
        if (r) ph = -ph;
        send_sym(ph * 700, -ph * 400);
    endtask

    task automatic send_bit(input bit b, input bit inv, input bit raw_exp);
        exp_bitq.push_back(raw_exp ? int'(b ^ inv) : int'(b));
        send_raw(b ^ inv);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit inv, input int evc);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && evc != 0) exp_evq.push_back(evc);
            send_bit(b[i], inv, 1'b0);
        end
    endtask

    task automatic send_sync(input bit inv);
        send_raw(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b1);
        for (int i = 15; i >= 0; i--) begin
            if (i == 0) exp_evq.push_back(EV_START);
            send_bit(SYNC[i], inv, 1'b1);
        end
        check("locked_after_sync", locked, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b0; strobe_in = 1'b0; sync_in = 1'b0;
        repeat (3) tick();
        check("reset_outputs", outvec(), 0);
        rst = 1'b0;
        prev_bv = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        repeat (4) tick();
        check({tag, "_bitq_empty"}, exp_bitq.size(), 0);
        check({tag, "_evq_empty"}, exp_evq.size(), 0);
        check({tag, "_unlocked"}, locked, 0);
    endtask

    initial begin
        tbl = '{
            '{1000, 0, 0, 0},       '{-1000, 0, 1, 1},   '{-1000, 0, 1, 0},
            '{10, 20, 0, 0},        '{1000, 0, 0, 0},    '{1000, 0, 1, 0},
            '{0, -1000, 1, 0},      '{0, 1000, 1, 1},    '{-32768, -32768, 1, 1},
            '{-32768, -32768, 1, 0}, '{40, 24, 1, 1},    '{40, 23, 0, 0}
        };

        do_reset();

        // Bit decision table: latency 1, first/post-squelch symbols silent, no repeat at ce=0.
        for (int i = 0; i < 12; i++) begin
            DI_in = W'(tbl[i].di); DQ_in = W'(tbl[i].dq);
            ce = 1'b1; strobe_in = 1'b1; sync_in = 1'b1;
            tick();
            check($sformatf("vec%0d_valid", i), bit_valid, tbl[i].v);
            if (tbl[i].v != 0) check($sformatf("vec%0d_bit", i), bit_out, tbl[i].b);
            ce = 1'b0;
            tick();
            check($sformatf("vec%0d_no_repeat", i), {bit_valid, frame_err}, 0);
            strobe_in = 1'b0;
            tick();
        end
        send_sym(-40, 23);
        check("after_squelch_silent", bit_valid, 0);

        // Good frame, normal polarity
        do_reset();
        mon_en = 1'b1;
        send_sync(1'b0);
        send_byte(8'd2, 1'b0, 0);
        send_byte(8'h41, 1'b0, EV_BYTE | 32'h41);
        send_byte(8'h42, 1'b0, EV_BYTE | 32'h42);
        check("locked_in_check", locked, 1);
        send_byte(8'h83, 1'b0, EV_OK);
        drain("good");

        // Same frame, all bits inverted
        do_reset();
        send_sync(1'b1);
        send_byte(8'd2, 1'b1, 0);
        send_byte(8'h41, 1'b1, EV_BYTE | 32'h41);
        send_byte(8'h42, 1'b1, EV_BYTE | 32'h42);
        send_byte(8'h83, 1'b1, EV_OK);
        drain("inverted");

        // Length above MAX_LEN
        do_reset();
        send_sync(1'b0);
        send_byte(8'h40, 1'b0, EV_ERR);
        drain("badlen");

        // Wrong check byte
        do_reset();
        send_sync(1'b0);
        send_byte(8'd2, 1'b0, 0);
        send_byte(8'h41, 1'b0, EV_BYTE | 32'h41);
        send_byte(8'h42, 1'b0, EV_BYTE | 32'h42);
        send_byte(8'h84, 1'b0, EV_ERR);
        drain("badcheck");

        // Squelch mid-DATA: error, then the next symbol only reloads prev
        do_reset();
        send_sync(1'b0);
        send_byte(8'd2, 1'b0, 0);
        send_byte(8'h41, 1'b0, EV_BYTE | 32'h41);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        exp_evq.push_back(EV_ERR);
        send_sym(10, 20);
        check("squelch_unlocked", locked, 0);
        send_raw(1'b0);
        exp_bitq.push_back(1);
        send_raw(1'b1);
        drain("squelch");

        // Reset during DATA
        do_reset();
        send_sync(1'b0);
        send_byte(8'd2, 1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_hold%0d_outputs", i), outvec(), 0);
        end
        rst = 1'b0;
        tick();
        check("rst_release_outputs", outvec(), 0);
        drain("midreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
